alu_muldiv_sequencer: RTL and testbench

Multi-cycle controller that performs 16-bit unsigned multiply (MUL) and unsigned divide (DIVU) by sequencing the CPU's shared 16-bit adder/subtractor over 16 iterations. It sits beside the execute stage. While busy it claims the adder through `alu_grant`, and the execute-stage operand mux hands the adder to it. It stalls the pipeline until the result is ready.

---
 rtl/alu_muldiv_sequencer.sv | 110 +++++++++++
 tb/tb_alu_muldiv_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/alu_muldiv_sequencer.sv
// alu_muldiv_sequencer: 16-iteration unsigned MUL/DIVU sequencer driving the shared execute-stage adder
//   i_start/i_op/i_src_a/i_src_b : request, sampled in IDLE only
//   o_busy/o_pipe_stall/o_done   : state decodes (INIT..DONE busy, DONE pulse)
//   o_result_hi/o_result_lo      : MUL product hi/lo, DIVU remainder/quotient, held between DONEs
//   o_div_by_zero                : DIVU by 0 flag, held until the next accepted start
//   o_alu_*/i_alu_*              : shared adder operands out, sum/carry back (combinational loop)
module alu_muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic             o_busy,
  output logic             o_pipe_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result_hi,
  output logic [WIDTH-1:0] o_result_lo,
  output logic             o_div_by_zero,
  output logic             o_alu_grant,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic             o_alu_sub,
  output logic             o_alu_cin,
  input  logic [WIDTH-1:0] i_alu_sum,
  input  logic             i_alu_cout
);
  typedef enum logic [1:0] {S_IDLE, S_INIT, S_ITER, S_DONE} state_t;
  state_t r_state, w_next;
  logic r_op, r_dbz;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo, r_res_hi, r_res_lo;
  logic [3:0] r_cnt;
  logic w_grant, w_q, w_b_zero;
  logic [WIDTH-1:0] w_s, w_hi_nx, w_lo_nx;
  logic [WIDTH:0] w_p;
  always_ff @(posedge i_clk) r_state <= i_rst ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_start ? S_INIT : S_IDLE;
      S_INIT:  w_next = (r_op && w_b_zero) ? S_DONE : S_ITER;
      S_ITER:  w_next = (r_cnt == 4'd15) ? S_DONE : S_ITER;
      default: w_next = S_IDLE;
    endcase
  end
  assign w_grant  = r_state == S_ITER;
  assign w_b_zero = r_b == '0;
  // Divide: shifted partial remainder; a bit shifted out of rem means s >= B regardless of borrow
  assign w_s     = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_q     = r_hi[WIDTH-1] | i_alu_cout;
  // Multiply: 17-bit partial (carry kept) shifted right one place into {hi,lo}
  assign w_p     = r_lo[0] ? {i_alu_cout, i_alu_sum} : {1'b0, r_hi};
  assign w_hi_nx = r_op ? (w_q ? i_alu_sum : w_s) : w_p[WIDTH:1];
  assign w_lo_nx = r_op ? {r_lo[WIDTH-2:0], w_q} : {w_p[0], r_lo[WIDTH-1:1]};
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op     <= 1'b0;
      r_dbz    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_op  <= i_op;
          r_a   <= i_src_a;
          r_b   <= i_src_b;
          r_dbz <= 1'b0;
        end
        S_INIT: begin
          r_hi  <= '0;
          r_lo  <= r_a;
          r_cnt <= '0;
          if (r_op && w_b_zero) begin
            r_res_hi <= r_a;
            r_res_lo <= '1;
            r_dbz    <= 1'b1;
          end
        end
        S_ITER: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_res_hi <= w_hi_nx;
            r_res_lo <= w_lo_nx;
          end
        end
        default: ;
      endcase
    end
  end
  assign o_busy        = r_state != S_IDLE;
  assign o_pipe_stall  = o_busy;
  assign o_done        = r_state == S_DONE;
  assign o_alu_grant   = w_grant;
  assign o_alu_a       = w_grant ? (r_op ? w_s : r_hi) : '0;
  assign o_alu_b       = w_grant ? r_b : '0;
  assign o_alu_sub     = w_grant & r_op;
  assign o_alu_cin     = w_grant & r_op;
  assign o_result_hi   = r_res_hi;
  assign o_result_lo   = r_res_lo;
  assign o_div_by_zero = r_dbz;
endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// tb_alu_muldiv_sequencer: scoreboard bench for the MUL/DIVU sequencer with a behavioural adder
module tb_alu_muldiv_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, op = 1'b0;
  logic [15:0] src_a = '0, src_b = '0;
  logic busy, pipe_stall, done, div_by_zero, alu_grant, alu_sub, alu_cin, alu_cout;
  logic [15:0] result_hi, result_lo, alu_a, alu_b, alu_sum;
  typedef struct {logic [15:0] hi; logic [15:0] lo; logic dbz;} res_t;
  res_t sb[$];
  res_t mon_e;
  int n_chk = 0, n_err = 0, n_done = 0;
  alu_muldiv_sequencer #(.WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_src_a(src_a), .i_src_b(src_b),
    .o_busy(busy), .o_pipe_stall(pipe_stall), .o_done(done),
    .o_result_hi(result_hi), .o_result_lo(result_lo), .o_div_by_zero(div_by_zero),
    .o_alu_grant(alu_grant), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sub(alu_sub),
    .o_alu_cin(alu_cin), .i_alu_sum(alu_sum), .i_alu_cout(alu_cout)
  );
  always #5 clk = ~clk;
  assign {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_sub ? ~alu_b : alu_b} + {16'b0, alu_cin};
  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic res_t model(input logic o, input logic [15:0] a, input logic [15:0] b);
    res_t r;
    logic [31:0] p;
    p = {16'b0, a} * {16'b0, b};
    r.dbz = o && b == 0;
    r.hi  = !o ? p[31:16] : (b == 0 ? a : a % b);
    r.lo  = !o ? p[15:0] : (b == 0 ? 16'hFFFF : a / b);
    return r;
  endfunction
  always @(negedge clk) if (done) begin
    n_done++;
    check("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check("result_hi", result_hi, mon_e.hi);
      check("result_lo", result_lo, mon_e.lo);
      check("div_by_zero", div_by_zero, mon_e.dbz);
    end
  end
  task automatic run(input logic o, input logic [15:0] a, input logic [15:0] b,
                     input int ig0 = -1, input int ig1 = -1);
    int de, d0;
    res_t m;
    m  = model(o, a, b);
    de = m.dbz ? 2 : 18;
    d0 = n_done;
    op = o; src_a = a; src_b = b; start = 1'b1;
    sb.push_back(m);
    for (int k = 1; k <= de; k++) begin
      @(negedge clk);
      start = (k == ig0 || k == ig1);
      if (start) begin
        op = 1'($urandom_range(1));
        src_a = 16'($urandom);
        src_b = 16'($urandom);
      end
      check("busy", busy, 1);
      check("pipe_stall", pipe_stall, 1);
      check("alu_grant", alu_grant, k >= 2 && k <= 17 && !m.dbz);
      check("done", done, k == de);
      if (k == 1) begin
        check("dbz_clear", div_by_zero, 0);
        check("alu_ab_idle", {alu_a, alu_b, alu_sub, alu_cin}, 0);
      end
      if (k == 2 && !m.dbz) begin
        check("alu_b", alu_b, b);
        check("alu_sub", alu_sub, o);
        check("alu_cin", alu_cin, o);
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after", busy, 0);
    check("done_count", n_done - d0, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int d0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {busy, pipe_stall, done, div_by_zero, alu_grant, alu_sub, alu_cin}, 0);
    check("rst_res", {result_hi, result_lo}, 0);
    check("rst_alu", {alu_a, alu_b}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ctl", {busy, done, alu_grant}, 0);
    run(1'b0, 16'h1234, 16'h0010, 5, 18);
    run(1'b1, 16'd100, 16'd7);
    run(1'b0, 16'hFFFF, 16'hFFFF);
    run(1'b1, 16'hFFFF, 16'h8001);
    run(1'b1, 16'h1234, 16'h0000);
    repeat (3) @(negedge clk);
    check("dbz_hold", div_by_zero, 1);
    check("res_hold", result_lo, 16'hFFFF);
    run(1'b0, 16'h00FF, 16'h0101);
    for (int i = 0; i < 6; i++) begin
      logic o;
      logic [15:0] a, b;
      o = 1'($urandom_range(1));
      a = 16'($urandom);
      b = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
      run(o, a, b);
    end
    d0 = n_done;
    op = 1'b0; src_a = 16'h0F0F; src_b = 16'h3003; start = 1'b1;
    sb.push_back(model(1'b0, 16'h0F0F, 16'h3003));
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    check("abort_ctl", {busy, pipe_stall, done, div_by_zero, alu_grant, alu_sub, alu_cin}, 0);
    check("abort_res", {result_hi, result_lo}, 0);
    check("abort_alu", {alu_a, alu_b}, 0);
    repeat (25) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    run(1'b1, 16'hBEEF, 16'h0123);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
